transmissor_serial_piso: RTL and testbench

Parallel-in/serial-out transmitter that feeds the team's 4-bit serial-in shift register (serial input enters the MSB stage and shifts toward stage 0).
- Accepts a LARGURA-bit word through a carregar/pronto handshake.
- Shifts the word out one bit per clock, LSB first, with a qualifying ativo strobe.
- After LARGURA clocks the receiver holds Q3..Q0 = dado[3..0].
- Sits between a parallel producer and the serial link.

---
 rtl/transmissor_serial_piso_pkg.sv | 17 +
 rtl/transmissor_serial_piso_contador_bits.sv | 41 ++++
 rtl/transmissor_serial_piso.sv | 90 +++++++++
 tb/tb_transmissor_serial_piso.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/transmissor_serial_piso_pkg.sv
// Shared types and helpers for the PISO serial transmitter and its bench.
// Bit i of the parallel word is sent in the i-th active cycle of a frame.
package pkg_serial;

   localparam int LARGURA_PADRAO = 4;

   typedef enum logic [0:0] {
      OCIOSO     = 1'b0,
      DESLOCANDO = 1'b1
   } estado_t;

   // LSB-first: the cycle index within a frame equals the bit index.
   function automatic int ciclo_do_bit(input int indice_bit);
      return indice_bit;
   endfunction

endpackage

// File: rtl/transmissor_serial_piso_contador_bits.sv
// Bit-position counter for one frame: synchronous clear/increment with a
// terminal-count flag raised while the final bit position is held.
module contador_bits #(
   parameter int LARGURA   = 4,
   parameter int LARG_CONT = (LARGURA > 1) ? $clog2(LARGURA) : 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 limpar,
   input  logic                 incrementar,
   output logic [LARG_CONT-1:0] valor,
   output logic                 ultimo_bit
);

   localparam logic [LARG_CONT-1:0] TERMINAL = LARG_CONT'(LARGURA - 1);

   logic [LARG_CONT-1:0] contador_q;
   logic [LARG_CONT-1:0] contador_d;

   // Clear wins over increment so a reload always restarts at position 0.
   always_comb begin
      contador_d = contador_q;
      if (limpar) begin
         contador_d = '0;
      end else if (incrementar && (contador_q != TERMINAL)) begin
         contador_d = contador_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         contador_q <= '0;
      end else begin
         contador_q <= contador_d;
      end
   end

   assign valor      = contador_q;
   assign ultimo_bit = (contador_q == TERMINAL);

endmodule

// File: rtl/transmissor_serial_piso.sv
// Parallel-in/serial-out transmitter: loads a word on carregar && pronto and
// shifts it out LSB first, one bit per clock, with ativo/ultimo qualifiers.
module transmissor_serial_piso
   import pkg_serial::*;
#(
   parameter int LARGURA = LARGURA_PADRAO
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [LARGURA-1:0] dado,
   input  logic               carregar,
   output logic               pronto,
   output logic               saida,
   output logic               ativo,
   output logic               ultimo
);

   localparam int LARG_CONT = (LARGURA > 1) ? $clog2(LARGURA) : 1;

   estado_t              estado_q;
   estado_t              estado_d;
   logic [LARGURA-1:0]   desl_q;
   logic [LARGURA-1:0]   desl_d;
   logic                 limpar;
   logic                 incrementar;
   logic                 ultimo_bit;
   logic [LARG_CONT-1:0] contador;

   contador_bits #(
      .LARGURA   (LARGURA),
      .LARG_CONT (LARG_CONT)
   ) u_contador (
      .clock       (clock),
      .reset       (reset),
      .limpar      (limpar),
      .incrementar (incrementar),
      .valor       (contador),
      .ultimo_bit  (ultimo_bit)
   );

   always_comb begin
      estado_d    = estado_q;
      desl_d      = desl_q;
      limpar      = 1'b0;
      incrementar = 1'b0;
      case (estado_q)
         OCIOSO: begin
            if (carregar) begin
               estado_d = DESLOCANDO;
               desl_d   = dado;
               limpar   = 1'b1;
            end
         end
         DESLOCANDO: begin
            if (ultimo_bit) begin
               // Last-bit cycle: either chain the next word with no gap or go idle.
               limpar = 1'b1;
               if (carregar) begin
                  desl_d = dado;
               end else begin
                  estado_d = OCIOSO;
               end
            end else begin
               desl_d      = desl_q >> 1;
               incrementar = 1'b1;
            end
         end
         default: begin
            estado_d = OCIOSO;
            limpar   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q <= OCIOSO;
         desl_q   <= '0;
      end else begin
         estado_q <= estado_d;
         desl_q   <= desl_d;
      end
   end

   assign ativo  = (estado_q == DESLOCANDO);
   assign saida  = ativo & desl_q[0];
   assign ultimo = ativo & ultimo_bit;
   assign pronto = (estado_q == OCIOSO) || ((estado_q == DESLOCANDO) && ultimo_bit);

endmodule

// File: tb/tb_transmissor_serial_piso.sv
// Directed bench for the PISO transmitter at widths 4 and 8, including a
// 4-bit serial-in receiver (serial input enters Q3 and shifts toward Q0).
module tb_transmissor_serial_piso;
   import pkg_serial::*;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] dado4;
   logic       carregar4;
   logic       pronto4, saida4, ativo4, ultimo4;
   logic [7:0] dado8;
   logic       carregar8;
   logic       pronto8, saida8, ativo8, ultimo8;
   logic [3:0] rx_q;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   transmissor_serial_piso #(.LARGURA(4)) u_dut4 (
      .clock    (clock),
      .reset    (reset),
      .dado     (dado4),
      .carregar (carregar4),
      .pronto   (pronto4),
      .saida    (saida4),
      .ativo    (ativo4),
      .ultimo   (ultimo4)
   );

   transmissor_serial_piso #(.LARGURA(8)) u_dut8 (
      .clock    (clock),
      .reset    (reset),
      .dado     (dado8),
      .carregar (carregar8),
      .pronto   (pronto8),
      .saida    (saida8),
      .ativo    (ativo8),
      .ultimo   (ultimo8)
   );

   // Receiver shift register clocked on the same edges as the transmitter.
   always_ff @(posedge clock) begin
      if (ativo4) rx_q <= {saida4, rx_q[3:1]};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_idle4(input string tag);
      check({tag, " ativo"},  32'(ativo4),  32'd0);
      check({tag, " saida"},  32'(saida4),  32'd0);
      check({tag, " ultimo"}, 32'(ultimo4), 32'd0);
      check({tag, " pronto"}, 32'(pronto4), 32'd1);
   endtask

   logic [3:0] palavra;
   logic [7:0] esperado8;
   logic [7:0] palavra8;

   initial begin
      reset     = 1'b1;
      dado4     = '0;
      carregar4 = 1'b0;
      dado8     = '0;
      carregar8 = 1'b0;
      rx_q      = '0;

      // 1: reset then idle
      tick();
      tick();
      check_idle4("reset");
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_idle4($sformatf("idle%0d", i));
         tick();
      end

      // 2: single frame 1011
      palavra   = 4'b1011;
      dado4     = palavra;
      carregar4 = 1'b1;
      tick();
      carregar4 = 1'b0;
      dado4     = 4'h0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2 ativo%0d", i),  32'(ativo4),  32'd1);
         check($sformatf("t2 saida%0d", i),  32'(saida4),  32'(palavra[ciclo_do_bit(i)]));
         check($sformatf("t2 ultimo%0d", i), 32'(ultimo4), 32'(i == 3));
         check($sformatf("t2 pronto%0d", i), 32'(pronto4), 32'(i == 3));
         tick();
      end
      check_idle4("t2 fim");
      check("t2 rx", 32'(rx_q), 32'hB);
      $display("frame 1011 done: rx=%h", rx_q);

      // 3: back-to-back A then 5 -> 0,1,0,1,1,0,1,0
      esperado8 = 8'b0101_1010;
      dado4     = 4'hA;
      carregar4 = 1'b1;
      tick();
      carregar4 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            dado4     = 4'h5;
            carregar4 = 1'b1;
         end else begin
            carregar4 = 1'b0;
         end
         check($sformatf("t3 ativo%0d", i),  32'(ativo4),  32'd1);
         check($sformatf("t3 saida%0d", i),  32'(saida4),  32'(esperado8[i]));
         check($sformatf("t3 ultimo%0d", i), 32'(ultimo4), 32'((i == 3) || (i == 7)));
         tick();
      end
      carregar4 = 1'b0;
      check_idle4("t3 fim");
      $display("back-to-back A,5 done");

      // 4: load attempt while busy is ignored
      palavra   = 4'h3;
      dado4     = palavra;
      carregar4 = 1'b1;
      tick();
      carregar4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin
            dado4     = 4'hF;
            carregar4 = 1'b1;
            check("t4 pronto ocupado", 32'(pronto4), 32'd0);
         end else begin
            carregar4 = 1'b0;
         end
         check($sformatf("t4 saida%0d", i), 32'(saida4), 32'(palavra[i]));
         check($sformatf("t4 ativo%0d", i), 32'(ativo4), 32'd1);
         tick();
      end
      check_idle4("t4 fim");
      tick();
      check_idle4("t4 depois");
      $display("ignored load done");

      // 5: reset mid-frame, carregar ignored on the reset edge
      dado4     = 4'hC;
      carregar4 = 1'b1;
      tick();
      carregar4 = 1'b0;
      check("t5 saida0", 32'(saida4), 32'd0);
      tick();
      check("t5 saida1", 32'(saida4), 32'd0);
      reset     = 1'b1;
      dado4     = 4'hF;
      carregar4 = 1'b1;
      tick();
      reset     = 1'b0;
      carregar4 = 1'b0;
      check_idle4("t5 reset");
      check("t5 contador", 32'(u_dut4.contador), 32'd0);
      palavra   = 4'h9;
      dado4     = palavra;
      carregar4 = 1'b1;
      tick();
      carregar4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t5 nova saida%0d", i), 32'(saida4), 32'(palavra[i]));
         check($sformatf("t5 nova ativo%0d", i), 32'(ativo4), 32'd1);
         tick();
      end
      check_idle4("t5 fim");
      $display("reset mid-frame done");

      // 6: width 8, 0x81
      palavra8  = 8'h81;
      dado8     = palavra8;
      check("t6 pronto inicial", 32'(pronto8), 32'd1);
      carregar8 = 1'b1;
      tick();
      carregar8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t6 ativo%0d", i),  32'(ativo8),  32'd1);
         check($sformatf("t6 saida%0d", i),  32'(saida8),  32'(palavra8[i]));
         check($sformatf("t6 ultimo%0d", i), 32'(ultimo8), 32'(i == 7));
         tick();
      end
      check("t6 fim ativo",  32'(ativo8),  32'd0);
      check("t6 fim pronto", 32'(pronto8), 32'd1);
      $display("width 8 frame 81 done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
